// File: rtl/fifo_spi_tx_pkg.sv
// Shared types and defaults for the FIFO-to-SPI transmit front end.
package fifo_spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SHIFT,
    GAP
  } tx_state_e;

  localparam int unsigned TX_FIFO_WIDTH = 16;
  localparam int unsigned TX_CLK_DIV    = 4;
  localparam int unsigned TX_GAP_CYC    = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_spi_tx_clk_div.sv
// SPI clock divider: sclk high in the second half of each bit period,
// bit_done marks the last clk cycle of a bit.
module spi_clk_div
  import fifo_spi_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = TX_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic bit_done
);

  localparam int unsigned DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] LAST    = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_M1 = DW'(CLK_DIV / 2 - 1);

  logic [DW-1:0] div_cnt;

  assign bit_done = run && (div_cnt == LAST);

  // sclk is registered, so it is raised one count early to be high while div_cnt >= CLK_DIV/2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (run) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
        sclk    <= 1'b0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
        if (div_cnt == HALF_M1) sclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_spi_tx.sv
// Drains a synchronous FIFO one word at a time and shifts each word
// MSB-first onto a mode-0 SPI master link.
module fifo_spi_tx
  import fifo_spi_tx_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = TX_FIFO_WIDTH,
  parameter int unsigned CLK_DIV    = TX_CLK_DIV,
  parameter int unsigned GAP_CYC    = TX_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  sclk,
  output logic                  ss_n,
  output logic                  mosi,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int unsigned BW = cnt_width(FIFO_WIDTH);
  localparam int unsigned GW = cnt_width(GAP_CYC);

  tx_state_e             state, state_next;
  logic [FIFO_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  bit_done;
  logic                  last_bit;
  logic                  gap_done;

  assign last_bit = bit_done && (bit_cnt == BW'(FIFO_WIDTH - 1));
  assign gap_done = (gap_cnt == GW'(GAP_CYC - 1));

  // mosi is the shift register MSB; shreg is cleared at word end so mosi idles low.
  assign mosi = shreg[FIFO_WIDTH-1];

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .run      (state == SHIFT),
    .clear    (state == LOAD),
    .sclk     (sclk),
    .bit_done (bit_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && !fifo_empty) state_next = READ;
      READ:    state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = GAP;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, shift register and word/gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_rd_en <= 1'b0;
      ss_n       <= 1'b1;
      busy       <= 1'b0;
      words_sent <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      fifo_rd_en <= (state_next == READ);
      busy       <= (state_next != IDLE);
      case (state)
        LOAD: begin
          shreg   <= fifo_dout;
          ss_n    <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (last_bit) begin
            shreg      <= '0;
            ss_n       <= 1'b1;
            words_sent <= words_sent + 16'd1;
            gap_cnt    <= '0;
          end else if (bit_done) begin
            shreg   <= {shreg[FIFO_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Scoreboard bench for fifo_spi_tx: a FIFO model feeds the DUT, words
// are queued as expected on push, and a monitor reassembles mosi on sclk
// rising edges and compares each completed word.
module tb_fifo_spi_tx;

  localparam int unsigned W   = 16;
  localparam int unsigned DIV = 4;
  localparam int unsigned GAP_C = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_dout  = '0;
  logic          fifo_rd_en;
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic          busy;
  logic [15:0]   words_sent;

  logic [W-1:0]  fifo_q[$];
  logic [W-1:0]  exp_q[$];

  int errors = 0;
  int checks = 0;

  // monitor state
  int          bits = 0;
  int          lowcnt = 0;
  int          highcnt = 0;
  int          rd_pulses = 0;
  int          rd_width = 0;
  logic [W-1:0] cap = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_ss = 1'b1;
  logic        prev_rd = 1'b0;
  bit          b2b = 1'b0;
  bit          gap_armed = 1'b0;

  fifo_spi_tx #(
    .FIFO_WIDTH (W),
    .CLK_DIV    (DIV),
    .GAP_CYC    (GAP_C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .busy       (busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Synchronous FIFO model with one-cycle read latency.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bits = 0; lowcnt = 0; cap = '0; rd_width = 0;
      prev_sclk = 1'b0; prev_ss = 1'b1; prev_rd = 1'b0; gap_armed = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        if (!prev_rd) rd_pulses++;
        rd_width++;
      end else if (prev_rd) begin
        check("rd_en_width", rd_width, 1);
        rd_width = 0;
      end
      if (!ss_n) begin
        if (prev_ss) begin
          // inter-word high time spans GAP plus the IDLE, READ and LOAD cycles
          if (gap_armed && b2b) check("ss_n_high_between_words", highcnt, GAP_C + 3);
          gap_armed = 1'b0;
          bits = 0;
          lowcnt = 0;
        end
        lowcnt++;
        if (sclk && !prev_sclk) begin
          cap = {cap[W-2:0], mosi};
          bits++;
        end
      end else begin
        if (!prev_ss) begin
          check("bits_per_word", bits, W);
          check("ss_n_low_cycles", lowcnt, W * DIV);
          if (exp_q.size() != 0) check("serial_word", cap, exp_q.pop_front());
          else begin
            checks++;
            errors++;
            $display("FAIL serial_word: got %h expected no word", cap);
          end
          highcnt = 0;
          gap_armed = b2b;
        end
        highcnt++;
      end
      prev_sclk = sclk;
      prev_ss   = ss_n;
      prev_rd   = fifo_rd_en;
    end
  end

  task automatic wait_done(input int ws, input int budget, input string name);
    int n = 0;
    bit ok;
    do begin
      @(negedge clk); #1;
      n++;
      ok = (words_sent == 16'(ws)) && !busy;
    end while (!ok && n < budget);
    check(name, ok, 1);
  endtask

  task automatic wait_bit(input int b, input int budget, input string name);
    int n = 0;
    bit ok;
    do begin
      @(negedge clk); #1;
      n++;
      ok = !ss_n && (bits == b);
    end while (!ok && n < budget);
    check(name, ok, 1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    push(16'hA5C3, 1'b1);

    // reset held with a non-empty FIFO and en high
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {fifo_rd_en, sclk, ss_n, mosi, busy, words_sent},
            {5'b00100, 16'h0000});
    end
    #1 rst = 1'b0;
    rd_pulses = 0;

    // single word and pop/ss_n latency
    @(negedge clk); check("latency_rd_en", {fifo_rd_en, ss_n}, 2'b11);
    @(negedge clk); check("latency_load", {fifo_rd_en, ss_n}, 2'b01);
    @(negedge clk); check("latency_ss_low", ss_n, 1'b0);
    wait_done(1, 300, "one_word_done");
    check("one_word_pops", rd_pulses, 1);
    check("one_word_count", words_sent, 16'd1);

    // empty FIFO with en high: nothing happens
    repeat (50) begin
      @(negedge clk);
      check("empty_idle", {fifo_rd_en, busy, ss_n}, 3'b001);
    end
    check("empty_no_pop", rd_pulses, 1);

    // three back-to-back words
    en = 1'b0;
    push(16'h0001, 1'b1);
    push(16'h8000, 1'b1);
    push(16'hFFFF, 1'b1);
    rd_pulses = 0;
    b2b = 1'b1;
    en = 1'b1;
    wait_done(4, 1000, "three_words_done");
    b2b = 1'b0;
    check("three_words_pops", rd_pulses, 3);
    check("three_words_count", words_sent, 16'd4);

    // en dropped mid-word: word completes, no further pop
    en = 1'b0;
    push(16'h1234, 1'b1);
    push(16'h5678, 1'b0);
    rd_pulses = 0;
    en = 1'b1;
    wait_bit(5, 300, "reach_bit5");
    en = 1'b0;
    wait_done(5, 300, "en_drop_done");
    repeat (20) @(negedge clk);
    check("en_drop_pops", rd_pulses, 1);
    check("en_drop_idle", {busy, ss_n}, 2'b01);
    check("en_drop_count", words_sent, 16'd5);

    // reset mid-word: 16'h5678 is lost, 16'h9ABC is popped fresh
    push(16'h9ABC, 1'b1);
    en = 1'b1;
    wait_bit(7, 300, "reach_bit7");
    #2 rst = 1'b1;
    #1 check("async_reset", {ss_n, sclk, mosi, busy, fifo_rd_en, words_sent},
             {5'b10000, 16'h0000});
    @(negedge clk);
    #1 rst = 1'b0;
    rd_pulses = 0;
    wait_done(1, 300, "post_reset_done");
    check("post_reset_pops", rd_pulses, 1);
    check("post_reset_count", words_sent, 16'd1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
